aes_subbytes_pipe: RTL



---
 rtl/aes_subbytes_pipe_pkg.sv | 83 ++++++++
 rtl/aes_subbytes_pipe_if.sv | 31 +++
 rtl/aes_subbytes_pipe_lane.sv | 41 ++++
 rtl/aes_subbytes_pipe.sv | 89 ++++++++
 4 files changed

// File: rtl/aes_subbytes_pipe_pkg.sv
// Shared types and helpers for the AES SubBytes/InvSubBytes pipeline.
// The S-box is computed as GF(2^8) inversion (x^254, AES polynomial 0x11B)
// wrapped in the AES affine transforms:
//   top layer    : inverse affine when dec=1, then a and a^2 (squaring is linear)
//   inversion    : a^3, a^12, a^15 (two multiplies plus one linear square chain)
//   bottom layer : a^240 * a^12 * a^2 = a^254, then forward affine when dec=0
// Zero maps to zero through the power chain, so no special case is needed.
package aes_subbytes_pipe_pkg;

  localparam int AES_BYTE_W = 8;

  // Known-answer vectors for four lanes: bytes 53 01 00 FF <-> ED 7C 63 16.
  localparam logic [31:0] KAT_FWD_IN  = 32'h5301_00FF;
  localparam logic [31:0] KAT_FWD_OUT = 32'hED7C_6316;

  typedef logic [AES_BYTE_W-1:0] byte_t;

  // Output of the top layer: the element to invert and its square.
  typedef struct packed {
    byte_t a;
    byte_t a2;
  } top_t;

  // Output of the inversion layer: partial powers still needed at the bottom.
  typedef struct packed {
    byte_t a15;
    byte_t a12;
    byte_t a2;
  } inv_t;

  function automatic byte_t rotl(byte_t x, int n);
    byte_t r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^(2^n)
  function automatic byte_t gf_sqn(byte_t a, int n);
    byte_t r;
    r = a;
    for (int i = 0; i < n; i++) r = gf_mul(r, r);
    return r;
  endfunction

  function automatic top_t top_layer(byte_t x, logic dec);
    top_t  t;
    byte_t a;
    a    = dec ? (rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05) : x;
    t.a  = a;
    t.a2 = gf_mul(a, a);
    return t;
  endfunction

  function automatic inv_t inv_layer(top_t t);
    inv_t  m;
    byte_t a3;
    a3    = gf_mul(t.a, t.a2);
    m.a12 = gf_sqn(a3, 2);
    m.a15 = gf_mul(m.a12, a3);
    m.a2  = t.a2;
    return m;
  endfunction

  function automatic byte_t bot_layer(inv_t m, logic dec);
    byte_t a254;
    a254 = gf_mul(gf_mul(gf_sqn(m.a15, 4), m.a12), m.a2);
    return dec ? a254
               : (a254 ^ rotl(a254, 1) ^ rotl(a254, 2) ^ rotl(a254, 3) ^ rotl(a254, 4) ^ 8'h63);
  endfunction

endpackage

// File: rtl/aes_subbytes_pipe_if.sv
// Beat interface of the SubBytes pipeline.
// master: producer/consumer side (drives in_*, out_ready, flush).
// slave : the engine (drives in_ready, out_*, busy).
interface aes_subbytes_pipe_if
  import aes_subbytes_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_dec;
  logic [AES_BYTE_W*LANES-1:0] in_data;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [AES_BYTE_W*LANES-1:0] out_data;
  logic [TAG_W-1:0]            out_tag;
  logic                        busy;

  modport master (
    output flush, in_valid, in_dec, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_dec, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/aes_subbytes_pipe_lane.sv
// One byte lane of the S-box pipeline: top layer into S0, optional mid
// register S1 after the inversion layer, bottom layer into the output register.
// No handshake here; the parent supplies per-stage load enables.
// Ports: clk, rst_n; ld[k] loads stage k; in_byte/in_dec feed the top layer;
// bot_dec is the mode of the beat entering the output register; out_byte.
module aes_subbytes_pipe_lane
  import aes_subbytes_pipe_pkg::*;
#(
  parameter int PIPE_MID = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIPE_MID+1:0] ld,
  input  logic              in_dec,
  input  logic              bot_dec,
  input  byte_t             in_byte,
  output byte_t             out_byte
);
  localparam int N = 2 + PIPE_MID;

  top_t top_q;
  inv_t inv_d;

  always_ff @(posedge clk)
    if (ld[0]) top_q <= top_layer(in_byte, in_dec);

  if (PIPE_MID != 0) begin : g_mid
    inv_t inv_q;
    always_ff @(posedge clk)
      if (ld[1]) inv_q <= inv_layer(top_q);
    assign inv_d = inv_q;
  end else begin : g_nomid
    assign inv_d = inv_layer(top_q);
  end

  // Output register is reset so out_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         out_byte <= '0;
    else if (ld[N-1])   out_byte <= bot_layer(inv_d, bot_dec);

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane pipelined AES SubBytes/InvSubBytes engine.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carrying
// flush, in_valid/in_ready/in_dec/in_data/in_tag, out_valid/out_ready/
// out_data/out_tag and busy. Latency N = 2 + PIPE_MID cycles, 1 beat/cycle.
// Owns the valid/stall chain, the per-stage mode bit and the tag; the lanes
// hold only data.
module aes_subbytes_pipe
  import aes_subbytes_pipe_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int PIPE_MID = 1,
  parameter int TAG_W    = 4
)(
  input logic               clk,
  input logic               rst_n,
  aes_subbytes_pipe_if.slave bus
);
  localparam int N      = 2 + PIPE_MID;
  localparam int STAGES = N - 1;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             adv;
  logic [STAGES:0]             ld;
  logic [N-2:0]                dec_q;   // output stage needs no mode bit
  logic [STAGES:0][TAG_W-1:0]  tag_q;
  logic [LANES-1:0][AES_BYTE_W-1:0] lane_out;

  // adv[k] = !v[k] || adv[k+1] unrolled: a stage can move unless it and
  // every stage after it are full and the output is stalled.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = STAGES; k >= 0; k--) begin
      full   = full & vld_pipe[k];
      adv[k] = bus.out_ready | ~full;
    end
  end

  // Load only when a real beat moves in, so stalled/empty stages keep data.
  always_comb begin
    ld    = '0;
    ld[0] = adv[0] & bus.in_valid;
    for (int k = 1; k <= STAGES; k++) ld[k] = adv[k] & vld_pipe[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dec_q    <= '0;
      tag_q    <= '0;
    end else begin
      if (bus.flush) begin
        vld_pipe <= '0;
      end else begin
        if (adv[0]) vld_pipe[0] <= bus.in_valid;
        for (int k = 1; k <= STAGES; k++)
          if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
      end
      if (ld[0]) begin
        dec_q[0] <= bus.in_dec;
        tag_q[0] <= bus.in_tag;
      end
      for (int k = 1; k <= STAGES; k++)
        if (ld[k]) tag_q[k] <= tag_q[k-1];
      for (int k = 1; k <= N - 2; k++)
        if (ld[k]) dec_q[k] <= dec_q[k-1];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_subbytes_pipe_lane #(.PIPE_MID(PIPE_MID)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld       (ld),
      .in_dec   (bus.in_dec),
      .bot_dec  (dec_q[N-2]),
      .in_byte  (bus.in_data[AES_BYTE_W*i +: AES_BYTE_W]),
      .out_byte (lane_out[i])
    );
  end

  assign bus.out_data  = lane_out;
  assign bus.out_tag   = tag_q[STAGES];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.in_ready  = adv[0];
  assign bus.busy      = |vld_pipe;

endmodule
